// File: rtl/lock_pkg.sv
// Shared types and constants for the digital lock: keypad buffer, display
// nibbles, PIN records and the configuration record published by setup.
package lock_pkg;

   localparam int NUM_FIELDS = 8;
   localparam int T_MIN      = 5;
   localparam int T_MAX      = 60;

   typedef logic [3:0] nibble_t;

   typedef struct packed {
      nibble_t [19:0] digits;
   } senhaPac_t;

   typedef struct packed {
      nibble_t [5:0] bcd;
   } bcdPac_t;

   typedef struct packed {
      logic           status;
      nibble_t [11:0] digits;
   } pinPac_t;

   typedef struct packed {
      logic       bip_status;
      logic [6:0] bip_time;
      logic [6:0] tranca_aut_time;
      pinPac_t    master_pin;
      pinPac_t    pin1;
      pinPac_t    pin2;
      pinPac_t    pin3;
      pinPac_t    pin4;
   } setupPac_t;

   typedef enum logic [3:0] {
      ST_IDLE, ST_AUTH,
      ST_F1, ST_F2, ST_F3, ST_F4, ST_F5, ST_F6, ST_F7, ST_F8,
      ST_DONE
   } setup_state_t;

   localparam nibble_t KEY_STAR = 4'hA;
   localparam nibble_t KEY_HASH = 4'hB;
   localparam nibble_t KEY_NONE = 4'hF;

   // Pin nibble 0 is the last digit typed, so 1234 is stored as ...F1234.
   localparam pinPac_t PIN_EMPTY = '{status: 1'b0, digits: {12{4'hF}}};
   localparam pinPac_t PIN_1234  = '{status: 1'b1,
                                    digits: {{8{4'hF}}, 4'h1, 4'h2, 4'h3, 4'h4}};

   localparam setupPac_t SETUP_DEFAULT = '{
      bip_status:      1'b1,
      bip_time:        7'd5,
      tranca_aut_time: 7'd5,
      master_pin:      PIN_1234,
      pin1:            PIN_EMPTY,
      pin2:            PIN_EMPTY,
      pin3:            PIN_EMPTY,
      pin4:            PIN_EMPTY
   };

   function automatic logic [7:0] time_bcd(input logic [6:0] t);
      return {4'(t / 7'd10), 4'(t % 7'd10)};
   endfunction

endpackage

// File: rtl/setup_entry_parser.sv
// Decodes a keypad buffer snapshot: the newest key plus the digit entry
// typed before it, as length, small decimal value and right-aligned pin.
module setup_entry_parser
   import lock_pkg::*;
(
   input  senhaPac_t      digitos_value,
   output nibble_t        key,
   output logic [4:0]     entry_len,
   output logic [7:0]     entry_dec,
   output nibble_t [11:0] entry_pin
);

   logic stop;

   always_comb begin
      key       = digitos_value.digits[0];
      entry_len = 5'd0;
      stop      = 1'b0;
      for (int i = 1; i < 20; i++) begin
         if (!stop) begin
            if (digitos_value.digits[i] == KEY_NONE) stop = 1'b1;
            else                                     entry_len = entry_len + 5'd1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 12; i++) begin
         entry_pin[i] = (5'(i) < entry_len) ? digitos_value.digits[i+1] : KEY_NONE;
      end
   end

   // Only one- and two-digit entries carry a meaningful decimal value.
   always_comb begin
      case (entry_len)
         5'd1:    entry_dec = 8'(digitos_value.digits[1]);
         5'd2:    entry_dec = 8'(digitos_value.digits[2]) * 8'd10 + 8'(digitos_value.digits[1]);
         default: entry_dec = 8'hFF;
      endcase
   end

endmodule

// File: rtl/setup.sv
// Setup-mode controller: authenticates the master PIN, edits eight
// configuration fields in a working copy and publishes it on exit.
module setup
   import lock_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         setup_on,
   input  senhaPac_t    digitos_value,
   input  logic         digitos_valid,
   output logic         display_en,
   output bcdPac_t      bcd_pac,
   output setupPac_t    data_setup_new,
   output logic         data_setup_ok,
   output setup_state_t state
);

   nibble_t        key;
   logic [4:0]     entry_len;
   logic [7:0]     entry_dec;
   nibble_t [11:0] entry_pin;
   setupPac_t      wc;
   setupPac_t      wc_upd;
   logic           entry_ok;
   logic           time_ok;
   logic           pin_ok;
   logic           pin_match;
   logic           key_strobe;
   logic           last_field;
   logic [3:0]     field_k;
   logic [3:0]     cur_idx;
   logic [3:0]     next_idx;

   setup_entry_parser u_parser (
      .digitos_value (digitos_value),
      .key           (key),
      .entry_len     (entry_len),
      .entry_dec     (entry_dec),
      .entry_pin     (entry_pin)
   );

   function automatic logic [15:0] field_view(input setupPac_t c, input logic [3:0] k);
      case (k)
         4'd1:    field_view = {12'hFFF, 3'b000, c.bip_status};
         4'd2:    field_view = {8'hFF, time_bcd(c.bip_time)};
         4'd3:    field_view = {8'hFF, time_bcd(c.tranca_aut_time)};
         4'd4:    field_view = c.master_pin.digits[3:0];
         4'd5:    field_view = c.pin1.digits[3:0];
         4'd6:    field_view = c.pin2.digits[3:0];
         4'd7:    field_view = c.pin3.digits[3:0];
         4'd8:    field_view = c.pin4.digits[3:0];
         default: field_view = 16'hFFFF;
      endcase
   endfunction

   assign field_k    = 4'(state) - 4'd1;
   assign cur_idx    = (state == ST_AUTH) ? 4'd0 : field_k;
   assign next_idx   = field_k + 4'd1;
   assign last_field = (field_k == 4'(NUM_FIELDS));
   assign key_strobe = digitos_valid && (key != KEY_NONE);
   assign time_ok    = (entry_len == 5'd1 || entry_len == 5'd2) &&
                       (entry_dec >= 8'(T_MIN)) && (entry_dec <= 8'(T_MAX));
   assign pin_ok     = (entry_len >= 5'd4) && (entry_len <= 5'd12);
   assign pin_match  = (entry_len <= 5'd12) && (entry_pin == wc.master_pin.digits);

   always_comb begin
      wc_upd   = wc;
      entry_ok = 1'b0;
      case (field_k)
         4'd1: if (entry_len == 5'd1 && entry_dec <= 8'd1) begin
            entry_ok          = 1'b1;
            wc_upd.bip_status = entry_dec[0];
         end
         4'd2: if (time_ok) begin
            entry_ok        = 1'b1;
            wc_upd.bip_time = entry_dec[6:0];
         end
         4'd3: if (time_ok) begin
            entry_ok               = 1'b1;
            wc_upd.tranca_aut_time = entry_dec[6:0];
         end
         4'd4: if (pin_ok) begin
            entry_ok          = 1'b1;
            wc_upd.master_pin = '{status: 1'b1, digits: entry_pin};
         end
         4'd5: if (pin_ok) begin
            entry_ok    = 1'b1;
            wc_upd.pin1 = '{status: 1'b1, digits: entry_pin};
         end
         4'd6: if (pin_ok) begin
            entry_ok    = 1'b1;
            wc_upd.pin2 = '{status: 1'b1, digits: entry_pin};
         end
         4'd7: if (pin_ok) begin
            entry_ok    = 1'b1;
            wc_upd.pin3 = '{status: 1'b1, digits: entry_pin};
         end
         4'd8: if (pin_ok) begin
            entry_ok    = 1'b1;
            wc_upd.pin4 = '{status: 1'b1, digits: entry_pin};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= ST_IDLE;
         wc             <= SETUP_DEFAULT;
         data_setup_new <= SETUP_DEFAULT;
         data_setup_ok  <= 1'b0;
         display_en     <= 1'b0;
         bcd_pac        <= '1;
      end else begin
         case (state)
            ST_IDLE: if (setup_on) begin
               state         <= ST_AUTH;
               display_en    <= 1'b1;
               data_setup_ok <= 1'b0;
               wc            <= data_setup_new;
               bcd_pac       <= {4'h0, 20'hFFFFF};
            end
            ST_DONE: state <= ST_IDLE;
            default: if (key_strobe) begin
               if (key <= 4'd9) begin
                  bcd_pac <= {cur_idx, 4'hF, digitos_value.digits[3:0]};
               end else if (state == ST_AUTH) begin
                  if (key == KEY_HASH) begin
                     state      <= ST_IDLE;
                     display_en <= 1'b0;
                     bcd_pac    <= '1;
                  end else if (key == KEY_STAR) begin
                     if (pin_match) begin
                        state   <= ST_F1;
                        bcd_pac <= {4'h1, 4'hF, field_view(wc, 4'd1)};
                     end else begin
                        bcd_pac <= {4'h0, 20'hFFFFF};
                     end
                  end
               end else if (key == KEY_HASH || (key == KEY_STAR && last_field)) begin
                  // Any entry pending with the exit key is dropped, not written.
                  state          <= ST_DONE;
                  data_setup_new <= wc;
                  data_setup_ok  <= 1'b1;
                  display_en     <= 1'b0;
                  bcd_pac        <= '1;
               end else if (key == KEY_STAR) begin
                  if (entry_len == 5'd0 || entry_ok) begin
                     wc      <= wc_upd;
                     state   <= setup_state_t'(4'(state) + 4'd1);
                     bcd_pac <= {next_idx, 4'hF, field_view(wc, next_idx)};
                  end else begin
                     bcd_pac <= {cur_idx, 4'hF, field_view(wc, cur_idx)};
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_setup.sv
// Bench for the setup controller: directed sessions followed by random
// sessions, all scored against a key-by-key model of the setup rules.
module tb_setup;
   import lock_pkg::*;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         setup_on = 1'b0;
   logic         digitos_valid = 1'b0;
   senhaPac_t    digitos_value = '1;
   logic         display_en;
   bcdPac_t      bcd_pac;
   setupPac_t    data_setup_new;
   logic         data_setup_ok;
   setup_state_t state;

   always #5 clk = ~clk;

   setup dut (
      .clk            (clk),
      .rst            (rst),
      .setup_on       (setup_on),
      .digitos_value  (digitos_value),
      .digitos_valid  (digitos_valid),
      .display_en     (display_en),
      .bcd_pac        (bcd_pac),
      .data_setup_new (data_setup_new),
      .data_setup_ok  (data_setup_ok),
      .state          (state)
   );

   localparam int M_IDLE = 0;
   localparam int M_AUTH = 100;

   int           n_cmp = 0;
   int           n_bad = 0;
   logic [3:0]   typed[$];
   logic [299:0] exp_q[$];
   int           mode = M_IDLE;
   setupPac_t    exp_cfg = SETUP_DEFAULT;
   setupPac_t    wcopy = SETUP_DEFAULT;
   logic         exp_en = 1'b0;
   logic         exp_ok = 1'b0;

   task automatic check(input string tag, input logic [299:0] obs, input logic [299:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic setup_state_t exp_state();
      case (mode)
         M_IDLE:  return ST_IDLE;
         M_AUTH:  return ST_AUTH;
         1:       return ST_F1;
         2:       return ST_F2;
         3:       return ST_F3;
         4:       return ST_F4;
         5:       return ST_F5;
         6:       return ST_F6;
         7:       return ST_F7;
         8:       return ST_F8;
         default: return ST_DONE;
      endcase
   endfunction

   function automatic logic [47:0] typed_pin();
      logic [47:0] r;
      for (int i = 0; i < 12; i++) r[i*4 +: 4] = (i < typed.size()) ? typed[i] : 4'hF;
      return r;
   endfunction

   function automatic int typed_dec();
      int v = 0;
      for (int i = typed.size() - 1; i >= 0; i--) v = v * 10 + int'(typed[i]);
      return v;
   endfunction

   task automatic commit();
      exp_cfg = wcopy;
      exp_q.push_back(300'(wcopy));
      exp_ok = 1'b1;
      exp_en = 1'b0;
      mode   = M_IDLE;
   endtask

   task automatic model_key(input logic [3:0] key);
      int          n = typed.size();
      int          v = typed_dec();
      logic [47:0] p = typed_pin();
      bit          good = 0;
      pinPac_t     np;
      if (mode == M_IDLE || key <= 4'd9 || key > KEY_HASH) return;
      np.status = 1'b1;
      np.digits = p;
      if (mode == M_AUTH) begin
         if (key == KEY_HASH) begin
            mode   = M_IDLE;
            exp_en = 1'b0;
         end else if (n <= 12 && p == wcopy.master_pin.digits) begin
            mode = 1;
         end
      end else if (key == KEY_HASH || mode == NUM_FIELDS) begin
         commit();
      end else if (n == 0) begin
         mode++;
      end else begin
         case (mode)
            1: good = (n == 1 && v <= 1);
            2, 3: good = (n <= 2 && v >= T_MIN && v <= T_MAX);
            default: good = (n >= 4 && n <= 12);
         endcase
         if (good) begin
            case (mode)
               1: wcopy.bip_status = (v == 1);
               2: wcopy.bip_time = 7'(v);
               3: wcopy.tranca_aut_time = 7'(v);
               4: wcopy.master_pin = np;
               5: wcopy.pin1 = np;
               6: wcopy.pin2 = np;
               7: wcopy.pin3 = np;
               default: wcopy.pin4 = np;
            endcase
            mode++;
         end
      end
   endtask

   task automatic check_outputs();
      check("display_en", 300'(display_en), 300'(exp_en));
      check("data_setup_ok", 300'(data_setup_ok), 300'(exp_ok));
      check("data_setup_new", 300'(data_setup_new), 300'(exp_cfg));
      while (exp_q.size() > 0) check("commit", 300'(data_setup_new), exp_q.pop_front());
   endtask

   // Strobe one key at a negedge; outputs are checked one cycle later.
   task automatic press(input logic [3:0] key);
      @(negedge clk);
      digitos_value = '1;
      digitos_value.digits[0] = key;
      for (int i = 0; i < typed.size() && i < 19; i++) digitos_value.digits[i+1] = typed[i];
      digitos_valid = 1'b1;
      model_key(key);
      if (key <= 4'd9) typed.push_front(key);
      else if (key == KEY_STAR || key == KEY_HASH) typed.delete();
      @(negedge clk);
      digitos_valid = 1'b0;
      check_outputs();
      @(negedge clk);
      check("state", 300'(state), 300'(exp_state()));
   endtask

   task automatic start();
      @(negedge clk);
      setup_on = 1'b1;
      if (mode == M_IDLE) begin
         mode   = M_AUTH;
         exp_en = 1'b1;
         exp_ok = 1'b0;
         wcopy  = exp_cfg;
      end
      @(negedge clk);
      setup_on = 1'b0;
      check_outputs();
      check("state_start", 300'(state), 300'(exp_state()));
   endtask

   task automatic type_num(input int val, input int len);
      int d = 1;
      for (int i = 1; i < len; i++) d = d * 10;
      for (int i = 0; i < len; i++) begin
         press(4'((val / d) % 10));
         d = d / 10;
      end
   endtask

   task automatic type_rand(input int len);
      repeat (len) press(4'($urandom_range(0, 9)));
   endtask

   task automatic type_master();
      int n = 0;
      for (int i = 0; i < 12; i++) if (wcopy.master_pin.digits[i] != 4'hF) n = i + 1;
      for (int i = n - 1; i >= 0; i--) press(wcopy.master_pin.digits[i]);
   endtask

   task automatic model_reset();
      mode    = M_IDLE;
      exp_cfg = SETUP_DEFAULT;
      wcopy   = SETUP_DEFAULT;
      exp_en  = 1'b0;
      exp_ok  = 1'b0;
      exp_q.delete();
      typed.delete();
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int steps;
      repeat (5000) @(posedge clk);
      @(negedge clk);
      check_outputs();
      check("reset_bcd", 300'(bcd_pac), 300'(24'hFFFFFF));
      check("reset_state", 300'(state), 300'(ST_IDLE));
      rst = 1'b1;

      start();
      type_num(1234, 4);
      press(KEY_STAR);
      check("bcd_field1", 300'(bcd_pac), 300'(24'h1FFFF1));
      press(KEY_HASH);
      check("default_cfg", 300'(data_setup_new), 300'(SETUP_DEFAULT));

      for (int i = 1; i <= 8; i++) begin
         start();
         type_num(1234, 4);
         press(KEY_STAR);
         repeat (i - 1) press(KEY_STAR);
         press(KEY_HASH);
         check("walk_cfg", 300'(data_setup_new), 300'(SETUP_DEFAULT));
         check("walk_ok", 300'(data_setup_ok), 300'(1'b1));
      end

      start();
      type_num(1234, 4);
      press(KEY_STAR);
      press(KEY_STAR);
      check("bcd_field2", 300'(bcd_pac), 300'(24'h2FFF05));
      type_num(99, 2);
      check("bcd_digits", 300'(bcd_pac), 300'(24'h2FFF99));
      press(KEY_STAR);
      check("stay_f2", 300'(state), 300'(ST_F2));
      press(KEY_HASH);
      check("bip_time_kept", 300'(data_setup_new.bip_time), 300'(7'd5));

      start();
      type_num(9999, 4);
      press(KEY_STAR);
      check("auth_blank", 300'(bcd_pac), 300'(24'h0FFFFF));
      check("auth_en", 300'(display_en), 300'(1'b1));
      press(KEY_HASH);
      check("abort_ok", 300'(data_setup_ok), 300'(1'b0));

      start();
      type_num(1234, 4);
      press(KEY_STAR);
      type_num(0, 1);
      press(KEY_STAR);
      type_num(30, 2);
      press(KEY_STAR);
      press(KEY_HASH);
      check("bip_status_0", 300'(data_setup_new.bip_status), 300'(1'b0));
      check("bip_time_30", 300'(data_setup_new.bip_time), 300'(7'd30));

      start();
      type_num(1234, 4);
      press(KEY_STAR);
      press(KEY_STAR);
      press(KEY_STAR);
      check("in_f3", 300'(state), 300'(ST_F3));
      #2 rst = 1'b0;
      model_reset();
      #1;
      check_outputs();
      check("rst_bcd", 300'(bcd_pac), 300'(24'hFFFFFF));
      check("rst_state", 300'(state), 300'(ST_IDLE));
      repeat (3) @(negedge clk);
      rst = 1'b1;
      start();
      check("auth_after_rst", 300'(state), 300'(ST_AUTH));
      press(KEY_HASH);

      for (int s = 0; s < 40; s++) begin
         start();
         if ($urandom_range(0, 9) < 8) type_master();
         else type_rand($urandom_range(1, 6));
         if ($urandom_range(0, 9) == 0) press(KEY_HASH);
         else press(KEY_STAR);
         steps = 0;
         while (mode != M_IDLE && steps < 40) begin
            steps++;
            case ($urandom_range(0, 19))
               0: press(KEY_HASH);
               1: press(KEY_NONE);
               2: start();
               default: begin
                  case ($urandom_range(0, 3))
                     0: ;
                     1: type_rand($urandom_range(1, 2));
                     2: press(4'($urandom_range(0, 1)));
                     default: type_rand($urandom_range(3, 13));
                  endcase
                  press(KEY_STAR);
               end
            endcase
         end
         if (mode != M_IDLE) press(KEY_HASH);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
